// File: rtl/alert_pkg.sv
// Shared definitions for the alert reporter slice.
// Holds the TX state encoding, the event record layout, the frame marker
// bit, and small helpers for building frame headers and saturating counts.
package alert_pkg;

    // Serializer state encoding.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Event record field widths.
    localparam int PRI_W  = 3;
    localparam int TYPE_W = 3;
    localparam int BMP_W  = 8;
    localparam int TS_W   = 8;
    localparam int REC_W  = PRI_W + TYPE_W + BMP_W + TS_W;

    // Event record field offsets.
    localparam int TS_LSB   = 0;
    localparam int BMP_LSB  = TS_LSB + TS_W;
    localparam int TYPE_LSB = BMP_LSB + BMP_W;
    localparam int PRI_LSB  = TYPE_LSB + TYPE_W;

    // MSB of byte0 is always set so the host can find frame starts.
    localparam logic FRAME_MARKER = 1'b1;

    // Event record: {priority, type, bitmap, timestamp}.
    typedef struct packed {
        logic [PRI_W-1:0]  pri;
        logic [TYPE_W-1:0] typ;
        logic [BMP_W-1:0]  bmp;
        logic [TS_W-1:0]   ts;
    } event_rec_t;

    // byte0 = {marker, priority, overflow flag, type}.
    function automatic logic [7:0] frame_hdr(input event_rec_t rec, input logic ovf);
        return {FRAME_MARKER, rec.pri, ovf, rec.typ};
    endfunction

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/alert_reporter_if.sv
// Detector-to-reporter alert bus.
// Signals: alert_any (any detector firing), alert_priority (7 = highest),
// alert_type (type code), alert_bitmap (per-detector hit bits).
// master = the anomaly detector side, slave = the alert reporter side.
interface alert_reporter_if;
    import alert_pkg::*;

    logic                alert_any;
    logic [PRI_W-1:0]    alert_priority;
    logic [TYPE_W-1:0]   alert_type;
    logic [BMP_W-1:0]    alert_bitmap;

    modport master (
        output alert_any,
        output alert_priority,
        output alert_type,
        output alert_bitmap
    );

    modport slave (
        input alert_any,
        input alert_priority,
        input alert_type,
        input alert_bitmap
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// Ports: clk, rst_n (async active-low), valid_i/data_i (byte offer),
// ready_o (byte accepted this edge when valid_i is high), tx_o (serial
// line, idle high), busy_o (high whenever not idle).
// A byte offered at the end of a stop bit is taken immediately, so the
// bytes of one frame go out with no idle gap between them.
module uart_tx_byte
    import alert_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        bit_end_s;

    assign bit_end_s = (baud_q == 16'd0);
    assign ready_o   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end_s);
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;

    // Serializer FSM: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (valid_i) begin
                        state_q <= TX_START;
                        baud_q  <= BAUD_RELOAD;
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end_s) begin
                        state_q   <= TX_DATA;
                        baud_q    <= BAUD_RELOAD;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_end_s) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_end_s) begin
                        if (valid_i) begin
                            state_q <= TX_START;
                            baud_q  <= BAUD_RELOAD;
                            shift_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= TX_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alert_reporter.sv
// Alert reporter: timestamps new detector alerts into a small FIFO and
// drains each entry as a 3-byte UART frame {hdr, bitmap, timestamp}.
// Ports: clk, rst_n (async active-low), det (alert bus, slave side),
// clr_sticky (sync clear of sticky_bitmap/event_count/overflow),
// uart_tx (serial out, idle high), tx_busy, irq (FIFO non-empty),
// sticky_bitmap, event_count (saturating), overflow (sticky drop flag).
module alert_reporter
    import alert_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alert_reporter_if.slave      det,
    input  logic                 clr_sticky,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 irq,
    output logic [7:0]           sticky_bitmap,
    output logic [7:0]           event_count,
    output logic                 overflow
);

    localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [TS_W-1:0]   ts_q;
    logic              last_any_q;
    logic [TYPE_W-1:0] last_type_q;

    event_rec_t        fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              pend_ovf_q;

    logic [15:0]       buf_q;
    logic [1:0]        byte_idx_q;
    logic              frame_q;

    logic [7:0]        sticky_q;
    logic [7:0]        count_q;
    logic              overflow_q;
    logic              irq_q;

    event_rec_t        new_rec_s;
    event_rec_t        head_s;
    logic              capture_s, full_s, empty_s, pop_s, push_s, drop_s;
    logic              byte_valid_s, byte_ready_s;
    logic [7:0]        byte_data_s;

    assign new_rec_s = {det.alert_priority, det.alert_type, det.alert_bitmap, ts_q};
    assign head_s    = fifo_q[rd_ptr_q[PTR_W-1:0]];

    // A new alert is a rising alert_any or a type change while it stays high.
    assign capture_s = det.alert_any && (!last_any_q || (det.alert_type != last_type_q));

    // The extra pointer bit tells full from empty when the index bits match.
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Pop only when the serializer is idle and no frame is in progress,
    // which guarantees an idle cycle between frames.
    assign pop_s  = !empty_s && !frame_q && !tx_busy;
    assign push_s = capture_s && (!full_s || pop_s);
    assign drop_s = capture_s && full_s && !pop_s;

    assign sticky_bitmap = sticky_q;
    assign event_count   = count_q;
    assign overflow      = overflow_q;
    assign irq           = irq_q;

    // Next FIFO pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Byte offered to the serializer: header on pop, then bitmap, then timestamp.
    always_comb begin
        byte_valid_s = 1'b0;
        byte_data_s  = 8'd0;
        if (pop_s) begin
            byte_valid_s = 1'b1;
            byte_data_s  = frame_hdr(head_s, pend_ovf_q);
        end else if (frame_q) begin
            byte_valid_s = 1'b1;
            byte_data_s  = (byte_idx_q == 2'd1) ? buf_q[15:8] : buf_q[7:0];
        end else begin
            byte_valid_s = 1'b0;
            byte_data_s  = 8'd0;
        end
    end

    // Free-running timestamp and previous-cycle detector copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q        <= '0;
            last_any_q  <= 1'b0;
            last_type_q <= '0;
        end else begin
            ts_q        <= ts_q + 8'd1;
            last_any_q  <= det.alert_any;
            last_type_q <= det.alert_type;
        end
    end

    // Event FIFO storage, pointers and the pending-overflow marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pend_ovf_q <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q[PTR_W-1:0]] <= new_rec_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (drop_s) begin
                pend_ovf_q <= 1'b1;
            end else if (pop_s) begin
                pend_ovf_q <= 1'b0;
            end
        end
    end

    // Frame sequencer: remembers bytes 1 and 2 while byte 0 is shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= 16'd0;
            byte_idx_q <= 2'd0;
            frame_q    <= 1'b0;
        end else if (pop_s) begin
            buf_q      <= {head_s.bmp, head_s.ts};
            byte_idx_q <= 2'd1;
            frame_q    <= 1'b1;
        end else if (frame_q && byte_ready_s) begin
            if (byte_idx_q == 2'd2) begin
                frame_q <= 1'b0;
            end else begin
                byte_idx_q <= byte_idx_q + 2'd1;
            end
        end
    end

    // Sticky status; a clear on the same edge wins over a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q   <= 8'd0;
            count_q    <= 8'd0;
            overflow_q <= 1'b0;
        end else if (clr_sticky) begin
            sticky_q   <= 8'd0;
            count_q    <= 8'd0;
            overflow_q <= 1'b0;
        end else begin
            if (capture_s) begin
                sticky_q <= sticky_q | det.alert_bitmap;
                count_q  <= sat_inc8(count_q);
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // IRQ reflects FIFO occupancy after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (wr_ptr_d != rd_ptr_d);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (byte_valid_s),
        .data_i  (byte_data_s),
        .ready_o (byte_ready_s),
        .tx_o    (uart_tx),
        .busy_o  (tx_busy)
    );

endmodule

// File: tb/tb_alert_reporter.sv
// Randomised and directed bench for alert_reporter with a queue-based
// reference model that predicts every output on every cycle.
module tb_alert_reporter;
    import alert_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 30 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_sticky = 1'b0;
    logic       uart_tx, tx_busy, irq, overflow;
    logic [7:0] sticky_bitmap, event_count;

    alert_reporter_if dif ();

    alert_reporter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .det           (dif),
        .clr_sticky    (clr_sticky),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .irq           (irq),
        .sticky_bitmap (sticky_bitmap),
        .event_count   (event_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [21:0] mq[$];
    logic [23:0] frames_log[$];
    logic [23:0] m_frame;
    int          m_ts, m_timer, m_count;
    bit          m_pend, m_ovf, m_last_any;
    logic [2:0]  m_last_type;
    logic [7:0]  m_sticky;

    function automatic void m_reset();
        mq.delete();
        frames_log.delete();
        m_frame = '0; m_ts = 0; m_timer = 0; m_count = 0;
        m_pend = 0; m_ovf = 0; m_last_any = 0; m_last_type = '0; m_sticky = '0;
    endfunction

    function automatic void m_step();
        bit cap;
        logic [21:0] rec;
        cap = dif.alert_any && (!m_last_any || dif.alert_type != m_last_type);
        if (m_timer == 0 && mq.size() > 0) begin
            rec = mq.pop_front();
            m_frame = {1'b1, rec[21:19], m_pend, rec[18:16], rec[15:8], rec[7:0]};
            m_pend = 0;
            frames_log.push_back(m_frame);
            m_timer = FRAME_CYC;
        end else if (m_timer > 0) begin
            m_timer--;
        end
        if (cap) begin
            if (mq.size() < DEPTH) mq.push_back({dif.alert_priority, dif.alert_type, dif.alert_bitmap, 8'(m_ts)});
            else begin m_ovf = 1; m_pend = 1; end
            m_sticky = m_sticky | dif.alert_bitmap;
            if (m_count < 255) m_count++;
        end
        if (clr_sticky) begin m_sticky = '0; m_count = 0; m_ovf = 0; end
        m_last_any = dif.alert_any;
        m_last_type = dif.alert_type;
        m_ts = (m_ts + 1) % 256;
    endfunction

    // Line level from position within the current frame.
    function automatic logic m_uart();
        int el, b, pos;
        if (m_timer == 0) return 1'b1;
        el  = FRAME_CYC - m_timer;
        b   = el / CPB;
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_frame[(2 - b / 10) * 8 + pos - 1];
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("uart_tx", uart_tx, m_uart());
                chk("tx_busy", tx_busy, m_timer != 0);
                chk("irq", irq, mq.size() != 0);
                chk("sticky_bitmap", sticky_bitmap, m_sticky);
                chk("event_count", event_count, m_count);
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit any, input logic [2:0] pri, input logic [2:0] typ, input logic [7:0] bmp);
        dif.alert_any = any; dif.alert_priority = pri; dif.alert_type = typ; dif.alert_bitmap = bmp;
    endtask

    task automatic do_reset();
        drive(0, 3'd0, 3'd0, 8'd0);
        clr_sticky = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 5000; i++) begin
            if (mq.size() == 0 && m_timer == 0 && !tx_busy && !irq) begin done = 1; break; end
            step();
        end
        chk("drain_bound", done, 1'b1);
        repeat (3) step();
    endtask

    initial begin
        drive(0, 3'd0, 3'd0, 8'd0);

        // 1: idle after reset
        do_reset();
        repeat (200) step();
        chk("t1_uart_idle", uart_tx, 1'b1);
        chk("t1_irq", irq, 1'b0);
        chk("t1_count", event_count, 8'd0);

        // 2: single alert sampled at timestamp 0x10
        do_reset();
        repeat (16) step();
        drive(1, 3'd7, 3'd7, 8'h80);
        step();
        chk("t2_line_high_at_capture", uart_tx, 1'b1);
        step();
        chk("t2_start_bit_latency", uart_tx, 1'b0);
        repeat (48) step();
        drive(0, 3'd0, 3'd0, 8'd0);
        drain();
        chk("t2_count", event_count, 8'd1);
        chk("t2_sticky", sticky_bitmap, 8'h80);
        chk("t2_nframes", frames_log.size(), 1);
        if (frames_log.size() > 0) chk("t2_frame", frames_log[0], 24'hF78010);

        // 3: type change while held
        do_reset();
        drive(1, 3'd3, 3'd0, 8'h05);
        repeat (5) step();
        drive(1, 3'd3, 3'd2, 8'h0A);
        repeat (5) step();
        drive(0, 3'd0, 3'd0, 8'd0);
        drain();
        chk("t3_count", event_count, 8'd2);
        chk("t3_sticky", sticky_bitmap, 8'h0F);
        chk("t3_nframes", frames_log.size(), 2);
        if (frames_log.size() == 2) begin
            chk("t3_f0_hdr", frames_log[0][23:16], 8'hB0);
            chk("t3_f1_hdr", frames_log[1][23:16], 8'hB2);
            chk("t3_ts_gap", 8'(frames_log[1][7:0] - frames_log[0][7:0]), 8'd5);
        end

        // 4: overflow burst, one capture per cycle
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(1, 3'd1, 3'(i), 8'(1 << i));
            step();
        end
        drive(0, 3'd0, 3'd0, 8'd0);
        step();
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_count", event_count, 8'd6);
        drain();
        chk("t4_nframes", frames_log.size(), 5);
        if (frames_log.size() == 5) begin
            chk("t4_f0_ovf", frames_log[0][19], 1'b0);
            chk("t4_f1_ovf", frames_log[1][19], 1'b1);
            chk("t4_f2_ovf", frames_log[2][19], 1'b0);
        end
        drive(1, 3'd2, 3'd3, 8'h01);
        step();
        drive(0, 3'd0, 3'd0, 8'd0);
        drain();
        if (frames_log.size() == 6) chk("t4_f6_ovf", frames_log[5][19], 1'b0);
        else chk("t4_nframes7", frames_log.size(), 6);

        // 5: saturation, then clear on a capture edge
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 3'd4, 3'd1, 8'h21);
            step();
            drive(0, 3'd0, 3'd0, 8'd0);
            step();
        end
        chk("t5_saturated", event_count, 8'd255);
        drive(1, 3'd4, 3'd6, 8'h42);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        drive(0, 3'd0, 3'd0, 8'd0);
        chk("t5_clr_count", event_count, 8'd0);
        chk("t5_clr_sticky", sticky_bitmap, 8'd0);
        chk("t5_clr_overflow", overflow, 1'b0);
        drain();

        // 6: reset in the middle of the data bits
        do_reset();
        drive(1, 3'd5, 3'd5, 8'h5A);
        step();
        drive(0, 3'd0, 3'd0, 8'd0);
        repeat (1 + CPB + 2 * CPB) step();
        chk("t6_busy_before", tx_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_uart", uart_tx, 1'b1);
        chk("t6_async_busy", tx_busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) step();
        chk("t6_no_residual_irq", irq, 1'b0);
        chk("t6_line_idle", uart_tx, 1'b1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            clr_sticky = ($urandom_range(0, 199) == 0);
            step();
        end
        clr_sticky = 1'b0;
        drive(0, 3'd0, 3'd0, 8'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
